// File: rtl/forwarding_hazard_unit.sv
// EX-stage forwarding select and load-use hazard controller.
// Tracks EX/MEM and MEM/WB destinations and freezes the front end for one cycle per load-use pair.
module forwarding_hazard_unit #(
  parameter int NREG_BITS = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_halt,
  input  logic [NREG_BITS-1:0] i_id_rs,
  input  logic [NREG_BITS-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic [NREG_BITS-1:0] i_ex_rd_rt,
  input  logic                 i_ex_regwrite,
  input  logic                 i_ex_memread,
  output logic [1:0]           o_cortocircuitoA,
  output logic [1:0]           o_cortocircuitoB,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_idex_bubble,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [NREG_BITS-1:0] r_idex_rs;
  logic [NREG_BITS-1:0] r_idex_rt;
  logic                 r_idex_uses_rt;
  logic [NREG_BITS-1:0] r_exmem_rd;
  logic                 r_exmem_regwrite;
  logic [NREG_BITS-1:0] r_memwb_rd;
  logic                 r_memwb_regwrite;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic w_ex_dst_nz;
  logic w_id_dep;
  logic w_stall;
  logic w_mem_valid;
  logic w_wb_valid;

  assign w_ex_dst_nz = (i_ex_rd_rt != '0);
  assign w_id_dep    = (i_ex_rd_rt == i_id_rs) ||
                       (i_id_uses_rt && (i_ex_rd_rt == i_id_rt));
  assign w_stall     = i_ex_memread && w_ex_dst_nz && w_id_dep && !i_halt;

  assign o_pc_write    = !w_stall && !i_halt;
  assign o_ifid_write  = !w_stall && !i_halt;
  assign o_idex_bubble = w_stall;

  // Register 0 is hardwired; a write to it must never be forwarded.
  assign w_mem_valid = r_exmem_regwrite && (r_exmem_rd != '0);
  assign w_wb_valid  = r_memwb_regwrite && (r_memwb_rd != '0);

  always_comb begin
    o_cortocircuitoA = SEL_REG;
    if (w_mem_valid && (r_exmem_rd == r_idex_rs))
      o_cortocircuitoA = SEL_MEM;
    else if (w_wb_valid && (r_memwb_rd == r_idex_rs))
      o_cortocircuitoA = SEL_WB;
  end

  always_comb begin
    o_cortocircuitoB = SEL_REG;
    if (r_idex_uses_rt) begin
      if (w_mem_valid && (r_exmem_rd == r_idex_rt))
        o_cortocircuitoB = SEL_MEM;
      else if (w_wb_valid && (r_memwb_rd == r_idex_rt))
        o_cortocircuitoB = SEL_WB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idex_rs        <= '0;
      r_idex_rt        <= '0;
      r_idex_uses_rt   <= 1'b0;
      r_exmem_rd       <= '0;
      r_exmem_regwrite <= 1'b0;
      r_memwb_rd       <= '0;
      r_memwb_regwrite <= 1'b0;
      r_stall_count    <= '0;
    end else if (!i_halt) begin
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_regwrite <= r_exmem_regwrite;
      r_exmem_rd       <= i_ex_rd_rt;
      r_exmem_regwrite <= i_ex_regwrite;
      if (w_stall) begin
        r_idex_rs      <= '0;
        r_idex_rt      <= '0;
        r_idex_uses_rt <= 1'b0;
        r_stall_count  <= r_stall_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_idex_rs      <= i_id_rs;
        r_idex_rt      <= i_id_rt;
        r_idex_uses_rt <= i_id_uses_rt;
      end
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed vector bench for forwarding_hazard_unit: pipeline streams with hand-computed selects,
// stall controls and counter values, plus a hand-written stall/reset sequence.
module tb_forwarding_hazard_unit;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_rd_rt;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  forwarding_hazard_unit #(.NREG_BITS(5), .CNT_WIDTH(32)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_halt           (halt),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_id_uses_rt     (id_uses_rt),
    .i_ex_rd_rt       (ex_rd_rt),
    .i_ex_regwrite    (ex_regwrite),
    .i_ex_memread     (ex_memread),
    .o_cortocircuitoA (sel_a),
    .o_cortocircuitoB (sel_b),
    .o_pc_write       (pc_write),
    .o_ifid_write     (ifid_write),
    .o_idex_bubble    (idex_bubble),
    .o_stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        halt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_u;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic        ex_mr;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic r, input logic h,
    input logic [4:0] rs, input logic [4:0] rt, input logic u,
    input logic [4:0] rd, input logic rw, input logic mr,
    input logic pcw, input logic ifw, input logic bub,
    input logic [1:0] a, input logic [1:0] b, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.halt = h; v.id_rs = rs; v.id_rt = rt; v.id_u = u;
    v.ex_rd = rd; v.ex_rw = rw; v.ex_mr = mr;
    v.pcw = pcw; v.ifw = ifw; v.bub = bub; v.a = a; v.b = b; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u, input logic [4:0] rd, input logic rw, input logic mr);
    rst = r; halt = h; id_rs = rs; id_rt = rt; id_uses_rt = u;
    ex_rd_rt = rd; ex_regwrite = rw; ex_memread = mr;
  endtask

  // Inputs change on the falling edge; hazard outputs are sampled before the rising edge,
  // registered selects and counter just after it.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.rst, v.halt, v.id_rs, v.id_rt, v.id_u, v.ex_rd, v.ex_rw, v.ex_mr);
    #1;
    chk("pc_write",    idx, {31'd0, pc_write},    {31'd0, v.pcw});
    chk("ifid_write",  idx, {31'd0, ifid_write},  {31'd0, v.ifw});
    chk("idex_bubble", idx, {31'd0, idex_bubble}, {31'd0, v.bub});
    @(posedge clk);
    #1;
    chk("selA",        idx, {30'd0, sel_a}, {30'd0, v.a});
    chk("selB",        idx, {30'd0, sel_b}, {30'd0, v.b});
    chk("stall_count", idx, stall_count, v.cnt);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    //                 rst  hlt  rs  rt  u     rd  rw  mr    pcw ifw bub  A      B      cnt
    vecs[0]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
    // MEM forwarding, rt unused
    vecs[1]  = mk(1'b0, 1'b0, 5'd3, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 32'd0);
    // WB forwarding: writer two ahead of consumer
    vecs[2]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
    vecs[3]  = mk(1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 32'd0);
    // both MEM and WB hold $5: MEM wins
    vecs[4]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
    vecs[5]  = mk(1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 32'd0);
    // register zero never forwarded
    vecs[6]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
    vecs[7]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
    // load-use on rs: one stall, then WB forwarding
    vecs[8]  = mk(1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd1);
    vecs[9]  = mk(1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 32'd1);
    // load matches rt but rt not read: no stall
    vecs[10] = mk(1'b0, 1'b0, 5'd1, 5'd4, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd1);
    // load-use on rt
    vecs[11] = mk(1'b0, 1'b0, 5'd2, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd2);
    vecs[12] = mk(1'b0, 1'b0, 5'd2, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 32'd2);
    // load to $0 never stalls
    vecs[13] = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd2);
    // halt during load-use: state frozen, no bubble
    vecs[14] = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd2);
    vecs[15] = mk(1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 32'd2);
    vecs[16] = mk(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'd2);
    vecs[17] = mk(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'd2);
    vecs[18] = mk(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'd3);
    vecs[19] = mk(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 32'd3);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Back-to-back stalls bring the counter from 3 to 7.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      #1;
      chk("seq_bubble", 100 + k, {31'd0, idex_bubble}, 32'd1);
      @(posedge clk);
      #1;
      chk("seq_count", 100 + k, stall_count, 32'd4 + 32'(k));
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_selA",  110, {30'd0, sel_a}, 32'd2);
    chk("pre_reset_count", 110, stall_count, 32'd7);

    // Reset while the load-use condition is present: no increment on this edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("reset_count", 111, stall_count, 32'd0);
    chk("reset_selA",  111, {30'd0, sel_a}, 32'd0);
    chk("reset_selB",  111, {30'd0, sel_b}, 32'd0);

    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("post_reset_pcw",    112, {31'd0, pc_write},    32'd1);
    chk("post_reset_ifw",    112, {31'd0, ifid_write},  32'd1);
    chk("post_reset_bubble", 112, {31'd0, idex_bubble}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_reset_count", 112, stall_count, 32'd0);
    chk("post_reset_selA",  112, {30'd0, sel_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Producer side of the EX-stage forwarding interface.
- Tracks the destination register and write-enable of the instructions in the EX/MEM and MEM/WB stages.
- Drives the two 2-bit forwarding selects consumed by the execute stage.
- Detects load-use hazards and generates stall/bubble controls for PC, IF/ID and ID/EX; keeps a stall counter for the debug unit.

Parameters:
- NREG_BITS, 5, register index width
- CNT_WIDTH, 32, stall counter width

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_halt  in  1  debug freeze: all internal state holds
- i_id_rs  in  NREG_BITS  rs of instruction in ID
- i_id_rt  in  NREG_BITS  rt of instruction in ID
- i_id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
- i_ex_rd_rt  in  NREG_BITS  resolved destination of instruction in EX (rd/rt mux output)
- i_ex_regwrite  in  1  EX instruction writes register file
- i_ex_memread  in  1  EX instruction is a load
- o_cortocircuitoA  out  2  forwarding select for ALU operand A
- o_cortocircuitoB  out  2  forwarding select for operand B (pre-ALUSrc mux)
- o_pc_write  out  1  PC update enable
- o_ifid_write  out  1  IF/ID register enable
- o_idex_bubble  out  1  load NOP into ID/EX
- o_stall_count  out  CNT_WIDTH  number of load-use stall cycles since reset

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Priority on each edge: i_reset > i_halt > normal advance.

Internal registers (all cleared to 0 on reset):
- idex_rs, idex_rt, idex_uses_rt: sources of the instruction now in EX.
- exmem_rd, exmem_regwrite: destination of the instruction in MEM.
- memwb_rd, memwb_regwrite: destination of the instruction in WB.

Normal advance, every cycle with !i_halt:
- memwb <= exmem.
- exmem_rd <= i_ex_rd_rt; exmem_regwrite <= i_ex_regwrite.
- idex <= ID sources, or all zeros when stall is asserted (bubble).

Halt:
- All registers and the counter hold.
- o_pc_write = o_ifid_write = 0; o_idex_bubble = 0.

Forwarding selects (combinational from registered state only; no input-to-output path). For operand A:
- 01 (MEM-stage ALU result) when exmem_regwrite && exmem_rd != 0 && exmem_rd == idex_rs.
- else 10 (WB write data) when memwb_regwrite && memwb_rd != 0 && memwb_rd == idex_rs.
- else 00 (register file value).
- Code 11 is never driven.
- Operand B uses the same rule with idex_rt, qualified by idex_uses_rt; 00 if !idex_uses_rt.
- When both MEM and WB match, MEM (01) wins: it holds the youngest value.
- Register 0 is never forwarded.

Load-use hazard:
- stall = i_ex_memread && i_ex_rd_rt != 0 && (i_ex_rd_rt == i_id_rs || (i_id_uses_rt && i_ex_rd_rt == i_id_rt)) && !i_halt.
- Stall outputs: o_pc_write = !stall, o_ifid_write = !stall, o_idex_bubble = stall.
- Exactly one stall cycle per load-use pair. Next cycle the load is in MEM, the ID/EX is a bubble, and stall deasserts.
- The dependent instruction then receives select 10 (WB forwarding) in its EX cycle.

Stall counter:
- Increments by 1 on each edge where stall=1 and not reset.
- Wraps to 0 at its maximum value.
- Holds under halt.

Reset values:
- Selects 00; o_stall_count 0.
- o_pc_write = o_ifid_write = 1 (derived from cleared state); o_idex_bubble = 0.

Reset mid-stall: the next cycle shows stall inputs re-evaluated from cleared state; the counter does not increment on the reset edge.

Latency: selects valid in the same cycle the consumer instruction occupies EX; hazard outputs are combinational in the same cycle as the ID/EX inputs.

Test Plan:
- MEM forwarding: add $3,$1,$2 in EX (i_ex_rd_rt=3, regwrite=1), next cycle idex_rs=3 -> o_cortocircuitoA=01, B=00.
- WB forwarding and priority: writer to $5 two cycles ahead, then consumer rs=rt=5 -> A=B=10; add a second writer to $5 one cycle ahead -> A=B=01.
- Register zero: writer with i_ex_rd_rt=0, regwrite=1, consumer rs=0 -> A=00.
- Load-use: lw $4 in EX (memread=1, rd_rt=4), ID rs=4 -> stall for exactly one cycle (o_pc_write=0, o_ifid_write=0, o_idex_bubble=1), o_stall_count 0->1; consumer later in EX sees A=10. Repeat with ID rt=4, i_id_uses_rt=0 -> no stall.
- Halt: assert i_halt during the load-use condition -> no bubble, pc/ifid writes 0, selects and counter frozen; on release the sequence resumes identically.
- Reset: assert i_reset during a stall and with the counter at 7 -> next edge: counter 0, selects 00, o_pc_write=1.
